// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate-extension unit.
package imm_ext_pkg;

    // Operation encodings carried on the 2-bit mode field.
    typedef enum logic [1:0] {
        MODE_ZX     = 2'd0,
        MODE_SX     = 2'd1,
        MODE_PREFIX = 2'd2,
        MODE_SXSHL  = 2'd3
    } mode_t;

    // Clamp a requested field width to the largest field the unit supports.
    function automatic int unsigned clamp_width(input int unsigned requested,
                                                input int unsigned max_w);
        return (requested > max_w) ? max_w : requested;
    endfunction

endpackage

// File: rtl/imm_ext_core.sv
// Combinational extension of a variable-width immediate field to OUT_W bits.
// The caller supplies an already-clamped width w (0..IN_W).
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int OUT_W = 16,
    parameter int IN_W  = 8,
    localparam int WS_W = $clog2(IN_W + 1)
) (
    input  logic [IN_W-1:0]  imm,
    input  logic [WS_W-1:0]  w,
    input  logic [1:0]       mode,
    output logic [OUT_W-1:0] ext
);

    logic [31:0]      w_ext;
    logic [OUT_W-1:0] zx;
    logic [OUT_W-1:0] sx;
    logic             sign;

    assign w_ext = 32'(w);

    // Keep only the low w bits, and pick bit w-1 as the sign (0 when w is 0).
    always_comb begin
        zx   = '0;
        sign = 1'b0;
        for (int i = 0; i < IN_W; i++) begin
            if (32'(i) < w_ext) begin
                zx[i] = imm[i];
            end
            if (32'(i + 1) == w_ext) begin
                sign = imm[i];
            end
        end
    end

    // Replicate the sign bit into every position at or above w.
    always_comb begin
        sx = zx;
        for (int i = 0; i < OUT_W; i++) begin
            if (32'(i) >= w_ext) begin
                sx[i] = sign;
            end
        end
    end

    // Select the extension flavour; PREFIX never produces an extended value.
    always_comb begin
        ext = '0;
        case (mode_t'(mode))
            MODE_ZX:    ext = zx;
            MODE_SX:    ext = sx;
            MODE_SXSHL: ext = {sx[OUT_W-2:0], 1'b0};
            default:    ext = '0;
        endcase
    end

endmodule

// File: rtl/imm_extender.sv
// Registered immediate extender with prefix-built constants and a one-entry
// valid/ready output register, feeding the ALU B-operand mux.
module imm_extender
    import imm_ext_pkg::*;
#(
    parameter int OUT_W    = 16,
    parameter int IN_W     = 8,
    parameter int PREFIX_W = 8,
    localparam int WS_W    = $clog2(IN_W + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  imm,
    input  logic [WS_W-1:0]  width_sel,
    input  logic [1:0]       mode,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] result,
    output logic             prefix_pending,
    output logic             prefix_overwrite
);

    localparam int LOW_W = OUT_W - PREFIX_W;

    if (IN_W > OUT_W) begin : g_chk_in_w
        $error("imm_extender: IN_W must not exceed OUT_W");
    end
    if (PREFIX_W < 1 || PREFIX_W >= OUT_W) begin : g_chk_prefix_range
        $error("imm_extender: PREFIX_W must be in 1..OUT_W-1");
    end
    if (LOW_W > IN_W) begin : g_chk_low_w
        $error("imm_extender: OUT_W - PREFIX_W must not exceed IN_W");
    end

    logic [WS_W-1:0]     w_eff;
    logic [OUT_W-1:0]    ext_value;
    logic [OUT_W-1:0]    combined;
    logic [PREFIX_W-1:0] prefix_in;
    logic [PREFIX_W-1:0] prefix_q;
    logic                accept;
    logic                is_prefix;
    logic                drain;

    assign w_eff = WS_W'(clamp_width(32'(width_sel), IN_W));

    imm_ext_core #(
        .OUT_W (OUT_W),
        .IN_W  (IN_W)
    ) u_core (
        .imm  (imm),
        .w    (w_eff),
        .mode (mode),
        .ext  (ext_value)
    );

    // Narrow immediate fields are zero-padded into the prefix register.
    if (IN_W >= PREFIX_W) begin : g_prefix_wide
        assign prefix_in = imm[PREFIX_W-1:0];
    end else begin : g_prefix_narrow
        assign prefix_in = {{(PREFIX_W - IN_W){1'b0}}, imm};
    end

    assign combined  = {prefix_q, imm[LOW_W-1:0]};
    assign in_ready  = !out_valid || out_ready;
    assign drain     = out_valid && out_ready;
    assign accept    = in_valid && in_ready && !flush;
    assign is_prefix = (mode_t'(mode) == MODE_PREFIX);

    // Output register: drains on handshake, reloads on any non-PREFIX accept;
    // a pending prefix overrides the normal extension for that op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else begin
            if (drain) begin
                out_valid <= 1'b0;
            end
            if (accept && !is_prefix) begin
                out_valid <= 1'b1;
                result    <= prefix_pending ? combined : ext_value;
            end
        end
    end

    // Prefix register and its pending flag; the overwrite pulse lasts one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prefix_q         <= '0;
            prefix_pending   <= 1'b0;
            prefix_overwrite <= 1'b0;
        end else begin
            prefix_overwrite <= 1'b0;
            if (flush) begin
                prefix_pending <= 1'b0;
            end else if (accept) begin
                if (is_prefix) begin
                    prefix_q         <= prefix_in;
                    prefix_pending   <= 1'b1;
                    prefix_overwrite <= prefix_pending;
                end else begin
                    prefix_pending <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/imm_extender.md
# imm_extender

Parametrised, registered immediate-extension unit for the 16-bit accumulator datapath. It generalises the fixed 1-bit sign extender to any field width selected per operation. It supports zero-extend, sign-extend, sign-extend-and-shift (branch offsets), and a two-instruction prefix mode that builds full-width constants. It sits between decode and the ALU B-operand mux, with a one-entry valid/ready output register.

## Interface
- OUT_W, 16: result width.
- IN_W, 8: maximum immediate field width; constraint IN_W ≤ OUT_W.
- PREFIX_W, 8: prefix register width; constraint OUT_W − PREFIX_W ≤ IN_W.
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  request present.
- in_ready  output  1  request accepted this cycle when in_valid && in_ready.
- imm  input  IN_W  raw immediate field, LSB-aligned.
- width_sel  input  $clog2(IN_W+1)  number of significant imm bits.
- mode  input  2  operation: 0 ZX, 1 SX, 2 PREFIX, 3 SXSHL.
- flush  input  1  discards the pending prefix and the output register.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result when out_valid && out_ready.
- result  output  OUT_W  extended value.
- prefix_pending  output  1  a prefix is held.
- prefix_overwrite  output  1  one-cycle pulse: PREFIX accepted while prefix_pending.

## Operation
- Effective width w = min(width_sel, IN_W); bits of imm above w are ignored.
- ZX: result = imm[w-1:0] zero-extended. w = 0 gives 0.
- SX: result = imm[w-1:0] with bit w−1 replicated to OUT_W. w = 0 gives 0.
- SXSHL: SX value shifted left 1, truncated to OUT_W.
- PREFIX: stores imm[PREFIX_W-1:0] (zero-padded if IN_W < PREFIX_W) and sets prefix_pending. Produces no output. width_sel is ignored.
- Prefix combine: any accepted non-PREFIX op while prefix_pending produces result = {prefix, imm[OUT_W-PREFIX_W-1:0]}. Mode and width_sel are ignored for that op, and prefix_pending clears on the same edge.
- A PREFIX accepted while prefix_pending overwrites the stored prefix and pulses prefix_overwrite. prefix_pending stays set.
- Flush: clears prefix_pending and out_valid at the next edge. An input handshaking in the same cycle is dropped. Flush has priority over every other event.

## Timing
- Reset (asynchronous assert, synchronous deassert by the external sync): out_valid = 0, result = 0, prefix_pending = 0, prefix_overwrite = 0, prefix register = 0.
- in_ready = !out_valid || out_ready. It is combinational and has no dependence on in_valid.
- Latency: a non-PREFIX op accepted at edge N shows out_valid = 1 and result after edge N; throughput is 1 per cycle.
- Stall: with out_valid && !out_ready, result and out_valid hold stable and in_ready = 0.
- Simultaneous output drain and input accept: the output register reloads with the new result with no bubble.
- An accepted PREFIX with output drained leaves out_valid = 0 the next cycle.
- prefix_overwrite is registered and high for exactly one cycle after the accepting edge.
- Reset mid-stall or mid-prefix discards all state; no output is produced for the interrupted op.

## Structure
- Shared package imm_ext_pkg holds the mode encodings (MODE_ZX, MODE_SX, MODE_PREFIX, MODE_SXSHL) as a 2-bit enum typedef.
- One combinational sub-module, imm_ext_core: takes imm, w, mode and returns the OUT_W extended value. The control and prefix register stay in imm_extender.
- Parameter constraints are checked at elaboration and fail with an error.

## Test plan
Defaults apply: OUT_W = 16, IN_W = 8, PREFIX_W = 8.
- Reset: hold rst_n = 0 → out_valid = 0, result = 16'h0000, prefix_pending = 0. Release with in_valid = 0 → all stay 0.
- Width sweep SX: imm = 8'hFF, width_sel = 1..8 → 16'hFFFF each time. imm = 8'h01, width_sel = 1 → 16'hFFFF. width_sel = 0 → 16'h0000. width_sel = 12 → treated as 8.
- ZX vs SX vs SXSHL: imm = 8'hA5, width_sel = 8 → ZX 16'h00A5, SX 16'hFFA5, SXSHL 16'hFF4A. Back-to-back at 1 result per cycle.
- Prefix build: PREFIX imm = 8'h12, then SX imm = 8'h34 width_sel = 3 → exactly one result, 16'h1234. prefix_pending is 1 between the two ops and 0 after.
- Overwrite and flush:
  - PREFIX 8'hAA then PREFIX 8'hBB → prefix_overwrite pulses once. The next ZX imm = 8'h01 gives 16'hBB01.
  - PREFIX then flush together with a ZX op → no result, prefix_pending = 0.
- Backpressure: hold out_ready = 0 with out_valid = 1 for 5 cycles → result stable and in_ready = 0. Release with in_valid held → new result appears the next cycle with no gap.
